// File: rtl/decim_avg_fifo_pkg.sv
// rtl/decim_avg_fifo_pkg.sv - sfix17_En16 format constants, sample type and clog2 helper
package decim_avg_fifo_pkg;

  localparam int SAMPLE_W    = 17;
  localparam int SAMPLE_FRAC = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - parameterised synchronous FIFO with level count and drop strobe
module sample_fifo
  import decim_avg_fifo_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   pop_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [clog2(DEPTH):0] level_o,
  output logic               drop_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/decim_avg_fifo.sv
// rtl/decim_avg_fifo.sv - accumulate-and-dump decimator with round-half-up feeding an output FIFO
module decim_avg_fifo
  import decim_avg_fifo_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic signed [WIDTH-1:0]    In1,
  output logic signed [WIDTH-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [clog2(FIFO_DEPTH):0] fifo_level,
  output logic                       overflow
);

  localparam int ACC_W = WIDTH + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0]   LAST_PHASE = '1;
  localparam logic signed [ACC_W-1:0] HALF       = ACC_W'(1) << (LOG2_DECIM - 1);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_DECIM-1:0]    phase_q, phase_d;
  logic                     overflow_q, overflow_d;
  logic signed [ACC_W-1:0]  in_ext, sum, rnd;
  logic [WIDTH-1:0]         result, head;
  logic                     last, push, empty, full, drop;
  logic                     unused_rnd_bits;

  assign in_ext = {{LOG2_DECIM{In1[WIDTH-1]}}, In1};
  assign sum    = acc_q + in_ext;
  assign rnd    = sum + HALF;
  // Taking the upper WIDTH bits is the arithmetic shift; the group sum never exceeds ACC_W.
  assign result = rnd[ACC_W-1:LOG2_DECIM];
  assign unused_rnd_bits = ^rnd[LOG2_DECIM-1:0];
  assign last   = (phase_q == LAST_PHASE);
  assign push   = clk_enable && last;

  always_comb begin
    acc_d      = acc_q;
    phase_d    = phase_q;
    overflow_d = overflow_q | drop;
    if (clk_enable) begin
      phase_d = phase_q + 1'b1;
      acc_d   = last ? '0 : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (result),
    .pop_i       (out_ready),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (fifo_level),
    .drop_o      (drop)
  );

  assign out_valid = !empty;
  assign out_data  = out_valid ? $signed(head) : '0;
  assign overflow  = overflow_q;

  logic unused_full;
  assign unused_full = full;

endmodule
